axi_rd_arbiter: RTL and testbench



---
 rtl/npc_axi_pkg.sv | 19 +
 rtl/axi_rd_arbiter_if.sv | 32 +++
 rtl/axi_rd_arbiter_rr_arb2.sv | 35 +++
 rtl/axi_rd_arbiter.sv | 116 +++++++++++
 tb/tb_axi_rd_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/npc_axi_pkg.sv
// Shared constants for the AXI4-Lite read sequencer: FSM states, RRESP codes, requester IDs.
package npc_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Requester-side and AXI read-channel signals of the read arbiter.
// master is the arbiter's view; slave is the requesters/AXI-slave environment view.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) ();
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [1:0]        rsp_done;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              bus_hang;

  modport master (
    input  req_valid, req_addr0, req_addr1, arready, rvalid, rdata, rresp,
    output rsp_done, rsp_data, rsp_err, busy, arvalid, araddr, rready, bus_hang
  );

  modport slave (
    output req_valid, req_addr0, req_addr1, arready, rvalid, rdata, rresp,
    input  rsp_done, rsp_data, rsp_err, busy, arvalid, araddr, rready, bus_hang
  );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-input round-robin picker; on a tie the port not granted last time wins.
// gnt_id/gnt_any are combinational from req; last_gnt advances only on update.
module rr_arb2
  import npc_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_id,
  output logic       gnt_any
);

  logic last_gnt_q;

  always_comb begin
    gnt_any = |req;
    gnt_id  = PORT_IFU;
    if (req == 2'b11) begin
      gnt_id = ~last_gnt_q;
    end else if (req[PORT_LSU]) begin
      gnt_id = PORT_LSU;
    end
  end

  // Reset to LSU so the IFU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= PORT_LSU;
    end else if (update) begin
      last_gnt_q <= gnt_id;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4-Lite read channel between IFU (port 0) and LSU (port 1), one transaction at a time.
// Best case 4 cycles per read; all outputs come straight from flops or the state register.
module axi_rd_arbiter
  import npc_axi_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int HANG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  axi_rd_arbiter_if.master  bus
);

  localparam int WD_W = $clog2(HANG_CYCLES + 1);
  localparam logic [WD_W-1:0] HANG_MAX = WD_W'(HANG_CYCLES);

  state_e            state_q;
  logic              gnt_id_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              arvalid_q;
  logic              rready_q;
  logic [1:0]        rsp_done_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              bus_hang_q, bus_hang_d;

  logic gnt_id;
  logic gnt_any;
  logic arb_update;

  assign arb_update = (state_q == IDLE) && gnt_any;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .update  (arb_update),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_id_q   <= PORT_IFU;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rsp_done_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            gnt_id_q  <= gnt_id;
            araddr_q  <= gnt_id ? bus.req_addr1 : bus.req_addr0;
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bus.rvalid) begin
            rready_q             <= 1'b0;
            rsp_data_q           <= bus.rdata;
            rsp_err_q            <= (bus.rresp != OKAY);
            rsp_done_q[gnt_id_q] <= 1'b1;
            state_q              <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Watchdog only observes; it saturates and never disturbs the handshake.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == IDLE) begin
      wd_cnt_d = '0;
    end else if ((state_q == ADDR || state_q == DATA) && wd_cnt_q != HANG_MAX) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
    bus_hang_d = bus_hang_q | (wd_cnt_d == HANG_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q   <= '0;
      bus_hang_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      bus_hang_q <= bus_hang_d;
    end
  end

  assign bus.arvalid  = arvalid_q;
  assign bus.araddr   = araddr_q;
  assign bus.rready   = rready_q;
  assign bus.rsp_done = rsp_done_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.bus_hang = bus_hang_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with HANG_CYCLES=8; cycle N means N rising edges after the request is driven.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .HANG_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total_cnt++; if (bus.arvalid !== 1'b0) $display("FAIL reset_arvalid got %0h want 0", bus.arvalid); else pass_cnt++;
    total_cnt++; if (bus.rready !== 1'b0) $display("FAIL reset_rready got %0h want 0", bus.rready); else pass_cnt++;
    total_cnt++; if (bus.rsp_done !== 2'b00) $display("FAIL reset_rsp_done got %b want 00", bus.rsp_done); else pass_cnt++;
    total_cnt++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %0h want 0", bus.rsp_err); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0h want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.bus_hang !== 1'b0) $display("FAIL reset_bus_hang got %0h want 0", bus.bus_hang); else pass_cnt++;
    total_cnt++; if (bus.rsp_data !== 64'h0) $display("FAIL reset_rsp_data got %0h want 0", bus.rsp_data); else pass_cnt++;
    total_cnt++; if (bus.araddr !== 64'h0) $display("FAIL reset_araddr got %0h want 0", bus.araddr); else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_ifu();
    bus.arready   = 1'b1;
    bus.rvalid    = 1'b1;
    bus.rresp     = 2'b00;
    bus.rdata     = 64'h0000_0013;
    bus.req_addr0 = 64'h8000_0000;
    bus.req_valid = 2'b01;
    step();
    total_cnt++; if (bus.araddr !== 64'h8000_0000) $display("FAIL single_araddr got %0h want 80000000", bus.araddr); else pass_cnt++;
    total_cnt++; if (bus.arvalid !== 1'b1 || bus.busy !== 1'b1) $display("FAIL single_addr_phase got arvalid=%0h busy=%0h want 1 1", bus.arvalid, bus.busy); else pass_cnt++;
    step();
    total_cnt++; if (bus.rready !== 1'b1 || bus.arvalid !== 1'b0) $display("FAIL single_data_phase got rready=%0h arvalid=%0h want 1 0", bus.rready, bus.arvalid); else pass_cnt++;
    step();
    total_cnt++; if (bus.rsp_done !== 2'b01) $display("FAIL single_rsp_done got %b want 01", bus.rsp_done); else pass_cnt++;
    total_cnt++; if (bus.rsp_data !== 64'h13) $display("FAIL single_rsp_data got %0h want 13", bus.rsp_data); else pass_cnt++;
    total_cnt++; if (bus.rsp_err !== 1'b0) $display("FAIL single_rsp_err got %0h want 0", bus.rsp_err); else pass_cnt++;
    bus.req_valid = 2'b00;
    step();
    total_cnt++; if (bus.rsp_done !== 2'b00 || bus.busy !== 1'b0) $display("FAIL single_idle got done=%b busy=%0h want 00 0", bus.rsp_done, bus.busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_addr [4];
    logic [1:0]  exp_done [4];
    exp_addr = '{64'h100, 64'h200, 64'h100, 64'h200};
    exp_done = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    bus.req_addr0 = 64'h100;
    bus.req_addr1 = 64'h200;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      total_cnt++; if (bus.araddr !== exp_addr[k]) $display("FAIL b2b_araddr[%0d] got %0h want %0h", k, bus.araddr, exp_addr[k]); else pass_cnt++;
      step();
      step();
      total_cnt++; if (bus.rsp_done !== exp_done[k]) $display("FAIL b2b_rsp_done[%0d] got %b want %b", k, bus.rsp_done, exp_done[k]); else pass_cnt++;
      step();
    end
    bus.req_valid = 2'b00;
    step();
  endtask

  task automatic test_stall();
    int arv_cnt, rr_cnt, done_cnt, busy_bad;
    logic [1:0] done_val;
    arv_cnt = 0; rr_cnt = 0; done_cnt = 0; busy_bad = 0; done_val = 2'b00;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rdata     = 64'h77;
    bus.req_valid = 2'b01;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (bus.arvalid === 1'b1) arv_cnt++;
      if (bus.rready === 1'b1) rr_cnt++;
      if (bus.rsp_done !== 2'b00) begin
        done_cnt++;
        done_val = bus.rsp_done;
        bus.req_valid = 2'b00;
      end
      if (c <= 11 && bus.busy !== 1'b1) busy_bad++;
      bus.arready = (c >= 6);
      bus.rvalid  = (c >= 10);
    end
    total_cnt++; if (arv_cnt != 6) $display("FAIL stall_arvalid_cycles got %0d want 6", arv_cnt); else pass_cnt++;
    total_cnt++; if (rr_cnt != 4) $display("FAIL stall_rready_cycles got %0d want 4", rr_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt != 1 || done_val !== 2'b01) $display("FAIL stall_done got count=%0d val=%b want 1 01", done_cnt, done_val); else pass_cnt++;
    total_cnt++; if (busy_bad != 0) $display("FAIL stall_busy got %0d low cycles want 0", busy_bad); else pass_cnt++;
  endtask

  task automatic test_slverr();
    bus.arready   = 1'b1;
    bus.rvalid    = 1'b1;
    bus.rresp     = 2'b10;
    bus.rdata     = 64'hDEAD;
    bus.req_addr1 = 64'h200;
    bus.req_valid = 2'b10;
    step();
    total_cnt++; if (bus.araddr !== 64'h200) $display("FAIL err_araddr got %0h want 200", bus.araddr); else pass_cnt++;
    step();
    step();
    total_cnt++; if (bus.rsp_done !== 2'b10) $display("FAIL err_rsp_done got %b want 10", bus.rsp_done); else pass_cnt++;
    total_cnt++; if (bus.rsp_err !== 1'b1) $display("FAIL err_rsp_err got %0h want 1", bus.rsp_err); else pass_cnt++;
    total_cnt++; if (bus.rsp_data !== 64'hDEAD) $display("FAIL err_rsp_data got %0h want dead", bus.rsp_data); else pass_cnt++;
    bus.req_valid = 2'b00;
    bus.rresp     = 2'b00;
    bus.rdata     = 64'h0;
    step();
    total_cnt++; if (bus.rsp_data !== 64'hDEAD || bus.rsp_err !== 1'b1) $display("FAIL err_hold got data=%0h err=%0h want dead 1", bus.rsp_data, bus.rsp_err); else pass_cnt++;
  endtask

  task automatic test_hang();
    do_reset();
    total_cnt++; if (bus.bus_hang !== 1'b0) $display("FAIL hang_initial got %0h want 0", bus.bus_hang); else pass_cnt++;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b1;
    bus.rdata     = 64'h55;
    bus.req_valid = 2'b01;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 8) begin
        total_cnt++; if (bus.bus_hang !== 1'b0) $display("FAIL hang_before got %0h want 0", bus.bus_hang); else pass_cnt++;
      end
      if (c == 9) begin
        total_cnt++; if (bus.bus_hang !== 1'b1) $display("FAIL hang_rise got %0h want 1", bus.bus_hang); else pass_cnt++;
      end
      if (bus.rsp_done !== 2'b00) bus.req_valid = 2'b00;
      bus.arready = (c >= 11);
    end
    total_cnt++; if (bus.bus_hang !== 1'b1 || bus.busy !== 1'b0) $display("FAIL hang_sticky got hang=%0h busy=%0h want 1 0", bus.bus_hang, bus.busy); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.bus_hang !== 1'b0) $display("FAIL hang_clear got %0h want 0", bus.bus_hang); else pass_cnt++;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.arready   = 1'b1;
    bus.rvalid    = 1'b0;
    bus.req_addr0 = 64'h100;
    bus.req_addr1 = 64'h200;
    bus.req_valid = 2'b01;
    step();
    step();
    total_cnt++; if (bus.rready !== 1'b1) $display("FAIL mid_in_data got rready=%0h want 1", bus.rready); else pass_cnt++;
    rst = 1'b1;
    bus.req_valid = 2'b00;
    #1;
    total_cnt++; if (bus.rready !== 1'b0 || bus.busy !== 1'b0 || bus.arvalid !== 1'b0) $display("FAIL mid_async got rready=%0h busy=%0h arvalid=%0h want 0 0 0", bus.rready, bus.busy, bus.arvalid); else pass_cnt++;
    total_cnt++; if (bus.araddr !== 64'h0) $display("FAIL mid_araddr got %0h want 0", bus.araddr); else pass_cnt++;
    step();
    total_cnt++; if (bus.rsp_done !== 2'b00) $display("FAIL mid_no_done got %b want 00", bus.rsp_done); else pass_cnt++;
    rst = 1'b0;
    bus.rvalid    = 1'b1;
    bus.req_valid = 2'b11;
    step();
    total_cnt++; if (bus.araddr !== 64'h100 || bus.arvalid !== 1'b1) $display("FAIL mid_regrant got araddr=%0h arvalid=%0h want 100 1", bus.araddr, bus.arvalid); else pass_cnt++;
    step();
    step();
    total_cnt++; if (bus.rsp_done !== 2'b01) $display("FAIL mid_done got %b want 01", bus.rsp_done); else pass_cnt++;
    bus.req_valid = 2'b00;
    step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_addr0 = '0;
    bus.req_addr1 = '0;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = 2'b00;
    test_reset();
    test_single_ifu();
    test_back_to_back();
    test_stall();
    test_slverr();
    test_hang();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
